// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// Default widths and write-back source encodings.
package wb_regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_CNT_W = 64;

    localparam logic WB_SRC_MEM = 1'b1;
    localparam logic WB_SRC_ALU = 1'b0;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Two-read, one-write architectural register file.
// x0 reads as zero; a same-cycle write is visible on the read ports.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage: cleared asynchronously, written on enabled rising edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: x0 forced to zero, then write-first bypass, then storage.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (we && (rs1_addr == waddr)) begin
            rs1_data = wdata;
        end
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (we && (rs2_addr == waddr)) begin
            rs2_data = wdata;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, register write enable and retire counter.
// Drives the register file and exposes the write-back value for forwarding.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WB_valid,
    input  logic             WB_WBSrc,
    input  logic             WB_RegWrite,
    input  logic [XLEN-1:0]  WB_LW_Read_data,
    input  logic [XLEN-1:0]  WB_ALU_Result,
    input  logic [AW-1:0]    WB_rd,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_we,
    output logic [CNT_W-1:0] instret
);

    logic [CNT_W-1:0] instret_q;

    // Result select and write enable; enable is held off while in reset.
    always_comb begin
        wb_data = WB_ALU_Result;
        if (WB_WBSrc == WB_SRC_MEM) begin
            wb_data = WB_LW_Read_data;
        end
        wb_we = reset & WB_valid & WB_RegWrite & (WB_rd != '0);
    end

    // Retired-instruction counter; bubbles do not count, wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (WB_valid) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret = instret_q;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (wb_we),
        .waddr    (WB_rd),
        .wdata    (wb_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vectors, spec-level model and per-cycle compare.
// Literal expectations pin the model at key points.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        WB_valid;
    logic        WB_WBSrc;
    logic        WB_RegWrite;
    logic [31:0] WB_LW_Read_data;
    logic [31:0] WB_ALU_Result;
    logic [4:0]  WB_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;

    wb_regfile dut (
        .clk             (clk),
        .reset           (reset),
        .WB_valid        (WB_valid),
        .WB_WBSrc        (WB_WBSrc),
        .WB_RegWrite     (WB_RegWrite),
        .WB_LW_Read_data (WB_LW_Read_data),
        .WB_ALU_Result   (WB_ALU_Result),
        .WB_rd           (WB_rd),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .wb_data         (wb_data),
        .wb_we           (wb_we),
        .instret         (instret)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_sel();
        return WB_WBSrc ? WB_LW_Read_data : WB_ALU_Result;
    endfunction

    function automatic logic m_we();
        return reset && WB_valid && WB_RegWrite && (WB_rd != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_we() && a == WB_rd) return m_sel();
        return m_regs[a];
    endfunction

    // Architectural model: what the register file and counter must hold.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 64'd0;
        end else if (WB_valid) begin
            m_cnt = m_cnt + 64'd1;
            if (WB_RegWrite && WB_rd != 5'd0) m_regs[WB_rd] = m_sel();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_rs1", {32'd0, rs1_data}, {32'd0, m_read(rs1_addr)});
            chk("cyc_rs2", {32'd0, rs2_data}, {32'd0, m_read(rs2_addr)});
            chk("cyc_wbdata", {32'd0, wb_data}, {32'd0, m_sel()});
            chk("cyc_wbwe", {63'd0, wb_we}, {63'd0, m_we()});
            chk("cyc_instret", instret, m_cnt);
        end
    end

    task automatic drive(input logic v, input logic src, input logic rw,
                         input logic [31:0] ld, input logic [31:0] alu,
                         input logic [4:0] rd);
        WB_valid = v;
        WB_WBSrc = src;
        WB_RegWrite = rw;
        WB_LW_Read_data = ld;
        WB_ALU_Result = alu;
        WB_rd = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1;
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        rs1_addr = 0;
        rs2_addr = 0;
        #3 reset = 0;
        #1 cmp_en = 1;
        repeat (2) @(posedge clk);
        #2 reset = 1;

        // 1: everything reads zero after reset
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            chk("rst_rs1", {32'd0, rs1_data}, 64'd0);
            chk("rst_rs2", {32'd0, rs2_data}, 64'd0);
        end
        chk("rst_instret", instret, 64'd0);
        chk("rst_wbwe", {63'd0, wb_we}, 64'd0);
        step();

        // 2: ALU write with same-cycle bypass
        drive(1, 0, 1, 32'h0, 32'hDEADBEEF, 5'd5);
        rs1_addr = 5;
        #1;
        chk("t2_bypass", {32'd0, rs1_data}, 64'hDEADBEEF);
        chk("t2_we", {63'd0, wb_we}, 64'd1);
        step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t2_stored", {32'd0, rs1_data}, 64'hDEADBEEF);

        // 3: load data selected
        drive(1, 1, 1, 32'h0000_1234, 32'hFFFF_FFFF, 5'd7);
        rs2_addr = 7;
        #1;
        chk("t3_wbdata", {32'd0, wb_data}, 64'h1234);
        chk("t3_bypass", {32'd0, rs2_data}, 64'h1234);
        step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t3_stored", {32'd0, rs2_data}, 64'h1234);

        // 4: write to x0 is dropped
        drive(1, 0, 1, 32'h0, 32'hA5A5A5A5, 5'd0);
        rs1_addr = 0;
        rs2_addr = 0;
        #1;
        chk("t4_we", {63'd0, wb_we}, 64'd0);
        chk("t4_wbdata", {32'd0, wb_data}, 64'hA5A5A5A5);
        chk("t4_rs1", {32'd0, rs1_data}, 64'd0);
        chk("t4_rs2", {32'd0, rs2_data}, 64'd0);
        step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t4_after", {32'd0, rs1_data}, 64'd0);

        // 5: flushed bubble writes nothing and is not counted
        drive(0, 0, 1, 32'h0, 32'h55, 5'd3);
        rs1_addr = 3;
        #1;
        chk("t5_we", {63'd0, wb_we}, 64'd0);
        chk("t5_rs1", {32'd0, rs1_data}, 64'd0);
        step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t5_reg3", {32'd0, rs1_data}, 64'd0);
        chk("t5_cnt", instret, 64'd3);
        drive(1, 0, 0, 32'd0, 32'h99, 5'd4);
        repeat (10) step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t5_cnt10", instret, 64'd13);

        // both ports and the write port on one register
        drive(1, 0, 1, 32'h0, 32'h77, 5'd12);
        rs1_addr = 12;
        rs2_addr = 12;
        #1;
        chk("dual_rs1", {32'd0, rs1_data}, 64'h77);
        chk("dual_rs2", {32'd0, rs2_data}, 64'h77);
        step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);

        // 6: reset mid-cycle discards pending write
        drive(1, 0, 1, 32'h0, 32'h11, 5'd9);
        rs1_addr = 9;
        step();
        drive(1, 0, 1, 32'h0, 32'h22, 5'd9);
        #1;
        chk("t6_bypass", {32'd0, rs1_data}, 64'h22);
        #1 reset = 0;
        #1;
        chk("t6_rs1_rst", {32'd0, rs1_data}, 64'd0);
        chk("t6_we_rst", {63'd0, wb_we}, 64'd0);
        chk("t6_cnt_rst", instret, 64'd0);
        step();
        reset = 1;
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t6_reg9", {32'd0, rs1_data}, 64'd0);
        chk("t6_cnt", instret, 64'd0);

        // first write after reset lands on the next edge
        drive(1, 0, 1, 32'h0, 32'h33, 5'd9);
        step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t6_rewrite", {32'd0, rs1_data}, 64'h33);
        chk("t6_cnt1", instret, 64'd1);

        // counter wrap
        @(negedge clk);
        #1;
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 0, 0, 32'd0, 32'd0, 5'd0);
        step();
        drive(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("wrap_post", instret, 64'd0);

        repeat (2) @(posedge clk);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
